// File: rtl/uart_tx_serializer.sv
// UART transmit serializer: pulls bytes from a TX FIFO and shifts out 16x-oversampled
// start/data/parity/stop frames on a registered txd line, with break override.
module uart_tx_serializer (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       baud_tick,
   input  logic       fifo_empty,
   input  logic [7:0] fifo_rd_data,
   input  logic       fifo_rd_valid,
   output logic       fifo_rd_en,
   input  logic [1:0] wls,
   input  logic       stb,
   input  logic       pen,
   input  logic       eps,
   input  logic       stick_par,
   input  logic       set_break,
   output logic       txd,
   output logic       tx_busy,
   output logic       temt
);

   // state  | meaning
   // IDLE   | line high, waiting for FIFO data
   // FETCH  | read issued, waiting for fifo_rd_valid
   // START  | start bit (low) for one bit period
   // DATA   | N data bits, LSB first
   // PARITY | optional parity bit
   // STOP   | stop bit(s): 16, 24 or 32 ticks high
   typedef enum logic [2:0] {
      S_IDLE,
      S_FETCH,
      S_START,
      S_DATA,
      S_PARITY,
      S_STOP
   } state_t;

   state_t     state;
   logic [3:0] tick_cnt;
   logic [2:0] bit_cnt;
   logic [7:0] shift_reg;
   logic [1:0] wls_q;
   logic       stb_q;
   logic       pen_q;
   logic       par_q;
   logic       line_q;

   logic [7:0] data_mask;
   logic       par_calc;
   logic       bit_end;
   logic       stop_end;
   logic [2:0] last_bit;
   logic       line_nxt;

   // Index of the final data bit is 4+wls, i.e. {1, wls}.
   assign last_bit = {1'b1, wls_q};
   assign bit_end  = baud_tick && (tick_cnt == 4'd15);

   always_comb begin
      data_mask = 8'hFF;
      case (wls)
         2'b00:   data_mask = 8'h1F;
         2'b01:   data_mask = 8'h3F;
         2'b10:   data_mask = 8'h7F;
         default: data_mask = 8'hFF;
      endcase
      if (stick_par)
         par_calc = ~eps;
      else if (eps)
         par_calc = ^(fifo_rd_data & data_mask);
      else
         par_calc = ~^(fifo_rd_data & data_mask);
   end

   always_comb begin
      stop_end = 1'b0;
      if (!stb_q)
         stop_end = (tick_cnt == 4'd15);
      else if (wls_q == 2'b00)
         stop_end = (bit_cnt == 3'd1) && (tick_cnt == 4'd7);
      else
         stop_end = (bit_cnt == 3'd1) && (tick_cnt == 4'd15);
   end

   // Line value the FSM will drive after this edge; txd registers it (or break).
   always_comb begin
      line_nxt = line_q;
      case (state)
         S_IDLE:   line_nxt = 1'b1;
         S_FETCH:  if (fifo_rd_valid) line_nxt = 1'b0;
         S_START:  if (bit_end) line_nxt = shift_reg[0];
         S_DATA: begin
            if (bit_end) begin
               if (bit_cnt == last_bit)
                  line_nxt = pen_q ? par_q : 1'b1;
               else
                  line_nxt = shift_reg[1];
            end
         end
         S_PARITY: if (bit_end) line_nxt = 1'b1;
         S_STOP:   line_nxt = 1'b1;
         default:  line_nxt = 1'b1;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= S_IDLE;
         tick_cnt   <= 4'd0;
         bit_cnt    <= 3'd0;
         shift_reg  <= 8'd0;
         wls_q      <= 2'd0;
         stb_q      <= 1'b0;
         pen_q      <= 1'b0;
         par_q      <= 1'b0;
         line_q     <= 1'b1;
         txd        <= 1'b1;
         fifo_rd_en <= 1'b0;
         tx_busy    <= 1'b0;
      end else begin
         fifo_rd_en <= 1'b0;
         line_q     <= line_nxt;
         txd        <= set_break ? 1'b0 : line_nxt;
         case (state)
            S_IDLE: begin
               if (!fifo_empty) begin
                  fifo_rd_en <= 1'b1;
                  tx_busy    <= 1'b1;
                  state      <= S_FETCH;
               end
            end
            S_FETCH: begin
               if (fifo_rd_valid) begin
                  shift_reg <= fifo_rd_data & data_mask;
                  wls_q     <= wls;
                  stb_q     <= stb;
                  pen_q     <= pen;
                  par_q     <= par_calc;
                  tick_cnt  <= 4'd0;
                  bit_cnt   <= 3'd0;
                  state     <= S_START;
               end
            end
            S_START: begin
               if (baud_tick) begin
                  tick_cnt <= tick_cnt + 4'd1;
                  if (tick_cnt == 4'd15) state <= S_DATA;
               end
            end
            S_DATA: begin
               if (baud_tick) begin
                  tick_cnt <= tick_cnt + 4'd1;
                  if (tick_cnt == 4'd15) begin
                     shift_reg <= shift_reg >> 1;
                     if (bit_cnt == last_bit) begin
                        bit_cnt <= 3'd0;
                        state   <= pen_q ? S_PARITY : S_STOP;
                     end else begin
                        bit_cnt <= bit_cnt + 3'd1;
                     end
                  end
               end
            end
            S_PARITY: begin
               if (baud_tick) begin
                  tick_cnt <= tick_cnt + 4'd1;
                  if (tick_cnt == 4'd15) state <= S_STOP;
               end
            end
            S_STOP: begin
               if (baud_tick) begin
                  if (stop_end) begin
                     tick_cnt <= 4'd0;
                     bit_cnt  <= 3'd0;
                     tx_busy  <= 1'b0;
                     state    <= S_IDLE;
                  end else begin
                     tick_cnt <= tick_cnt + 4'd1;
                     if (tick_cnt == 4'd15) bit_cnt <= bit_cnt + 3'd1;
                  end
               end
            end
            default: begin
               tx_busy <= 1'b0;
               state   <= S_IDLE;
            end
         endcase
      end
   end

   assign temt = fifo_empty & ~tx_busy;

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Bench for uart_tx_serializer: FIFO model, frame model built as (level, ticks) segments,
// and a per-cycle compare of txd / tx_busy / temt / fifo_rd_en against that model.
module tb_uart_tx_serializer;

   logic       clk = 1'b0;
   logic       rst_n = 1'b1;
   logic       baud_tick = 1'b0;
   logic       fifo_empty = 1'b1;
   logic [7:0] fifo_rd_data = 8'd0;
   logic       fifo_rd_valid = 1'b0;
   logic       fifo_rd_en;
   logic [1:0] wls = 2'b11;
   logic       stb = 1'b0;
   logic       pen = 1'b0;
   logic       eps = 1'b0;
   logic       stick_par = 1'b0;
   logic       set_break = 1'b0;
   logic       txd;
   logic       tx_busy;
   logic       temt;

   uart_tx_serializer dut (
      .clk(clk), .rst_n(rst_n), .baud_tick(baud_tick), .fifo_empty(fifo_empty),
      .fifo_rd_data(fifo_rd_data), .fifo_rd_valid(fifo_rd_valid), .fifo_rd_en(fifo_rd_en),
      .wls(wls), .stb(stb), .pen(pen), .eps(eps), .stick_par(stick_par),
      .set_break(set_break), .txd(txd), .tx_busy(tx_busy), .temt(temt)
   );

   always #5 clk = ~clk;

   int tests = 0;
   int fails = 0;

   logic [7:0] fifo_q[$];
   logic [7:0] pop_data = 8'd0;
   logic       pend = 1'b0;
   int         bcnt = 0;
   int         pushes = 0;

   int  seg_val[$];
   int  seg_len[$];
   int  seg_cnt = 0;
   int  brk_q = 0;
   int  cyc = 0;
   int  end_cyc = 0;
   bit  b2b = 0;
   int  frames = 0;
   int  rd_en_cnt = 0;
   int  rd_en_prev = 0;
   int  fv[16];
   int  fnb[16];
   int  fst[16];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Expected frame from the line-protocol rules, using the config present at fetch.
   task automatic load_frame(input logic [7:0] d);
      int n, dv, ones, b, p, k, vec, stop;
      n = 5 + int'(wls);
      dv = int'(d);
      ones = 0; k = 0; vec = 0;
      seg_val.push_back(0); seg_len.push_back(16); k++;
      for (int i = 0; i < n; i++) begin
         b = (dv >> i) & 1;
         ones += b;
         seg_val.push_back(b); seg_len.push_back(16);
         vec |= b << k; k++;
      end
      if (pen) begin
         if (stick_par) p = eps ? 0 : 1;
         else if (eps)  p = ones % 2;
         else           p = 1 - (ones % 2);
         seg_val.push_back(p); seg_len.push_back(16);
         vec |= p << k; k++;
      end
      stop = !stb ? 16 : ((wls == 2'b00) ? 24 : 32);
      seg_val.push_back(1); seg_len.push_back(stop);
      seg_cnt = 0;
      fv[frames] = vec; fnb[frames] = k; fst[frames] = stop;
      frames++;
   endtask

   // FIFO and baud-tick driver: inputs change only on falling edges.
   initial forever begin
      @(negedge clk);
      baud_tick = (bcnt == 0);
      bcnt = (bcnt == 2) ? 0 : bcnt + 1;
      if (!rst_n) begin
         pend = 1'b0;
         fifo_rd_valid = 1'b0;
      end else begin
         fifo_rd_valid = pend;
         fifo_rd_data  = pend ? pop_data : 8'hEE;
         pend = 1'b0;
         if (fifo_rd_en && fifo_q.size() > 0) begin
            pop_data = fifo_q.pop_front();
            pend = 1'b1;
         end
         fifo_empty = (fifo_q.size() == 0);
      end
   end

   // Model advance and compare, 2 time units after every rising edge.
   initial forever begin
      @(posedge clk);
      #2;
      cyc++;
      if (!rst_n) begin
         seg_val.delete(); seg_len.delete();
         seg_cnt = 0; brk_q = 0; b2b = 0; rd_en_prev = 0;
         check("reset_txd", 32'(txd), 32'd1);
         check("reset_busy", 32'(tx_busy), 32'd0);
         check("reset_rd_en", 32'(fifo_rd_en), 32'd0);
      end else begin
         brk_q = int'(set_break);
         if (seg_val.size() > 0 && baud_tick) begin
            seg_cnt++;
            if (seg_cnt == seg_len[0]) begin
               void'(seg_val.pop_front());
               void'(seg_len.pop_front());
               seg_cnt = 0;
               if (seg_val.size() == 0) begin
                  end_cyc = cyc;
                  b2b = (fifo_q.size() > 0) || pend;
               end
            end
         end
         if (fifo_rd_valid) begin
            if (b2b) check("frame_gap_le3", 32'((cyc - end_cyc) <= 3), 32'd1);
            b2b = 0;
            load_frame(fifo_rd_data);
         end
         check("txd", 32'(txd), 32'((brk_q != 0) ? 0 : ((seg_val.size() > 0) ? seg_val[0] : 1)));
         if (seg_val.size() > 0) begin
            check("busy_in_frame", 32'(tx_busy), 32'd1);
            check("temt_in_frame", 32'(temt), 32'd0);
            check("rd_en_in_frame", 32'(fifo_rd_en), 32'd0);
         end else if (fifo_q.size() == 0 && !pend && !fifo_rd_valid) begin
            check("busy_idle", 32'(tx_busy), 32'd0);
            check("temt_idle", 32'(temt), 32'd1);
         end
         if (fifo_rd_en) begin
            rd_en_cnt++;
            check("rd_en_fifo_nonempty", 32'(fifo_q.size() > 0), 32'd1);
            check("rd_en_one_clk", 32'(rd_en_prev), 32'd0);
         end
         rd_en_prev = int'(fifo_rd_en);
      end
   end

   task automatic cfg(input logic [1:0] w, input logic s, input logic p, input logic e,
                      input logic sp);
      wls = w; stb = s; pen = p; eps = e; stick_par = sp;
   endtask

   task automatic push(input logic [7:0] b);
      fifo_q.push_back(b);
      fifo_empty = 1'b0;
      pushes++;
   endtask

   task automatic wait_load(input int target);
      int n = 0;
      while (frames < target && n < 3000) begin @(negedge clk); n++; end
      check("frame_load_in_time", 32'(n < 3000), 32'd1);
   endtask

   task automatic wait_done(input int target);
      int n = 0;
      while (!(frames >= target && seg_val.size() == 0 && fifo_q.size() == 0 && !pend
               && !fifo_rd_valid) && n < 5000) begin
         @(negedge clk); n++;
      end
      check("frame_done_in_time", 32'(n < 5000), 32'd1);
      repeat (2) @(negedge clk);
   endtask

   initial begin
      #1 rst_n = 1'b0;
      repeat (3) @(negedge clk);
      check("por_txd", 32'(txd), 32'd1);
      check("por_temt", 32'(temt), 32'd1);
      rst_n = 1'b1;
      repeat (10) @(negedge clk);

      // 8N1, 0x55
      cfg(2'b11, 1'b0, 1'b0, 1'b0, 1'b0);
      push(8'h55);
      wait_done(1);
      check("8n1_bits", 32'(fv[0]), 32'h0AA);
      check("8n1_nbits", 32'(fnb[0]), 32'd9);
      check("8n1_stop", 32'(fst[0]), 32'd16);
      check("8n1_temt_after", 32'(temt), 32'd1);

      // 7E1, 0xC1; config is scrambled mid-frame and must not matter
      cfg(2'b10, 1'b0, 1'b1, 1'b1, 1'b0);
      push(8'hC1);
      wait_load(2);
      repeat (5) @(negedge clk);
      cfg(2'b00, 1'b1, 1'b0, 1'b0, 1'b1);
      wait_done(2);
      check("7e1_bits", 32'(fv[1]), 32'h082);
      check("7e1_nbits", 32'(fnb[1]), 32'd9);

      // 5 bits, 1.5 stop, stick parity with eps=0
      cfg(2'b00, 1'b1, 1'b1, 1'b0, 1'b1);
      push(8'h1F);
      wait_done(3);
      check("5s_bits", 32'(fv[2]), 32'h07E);
      check("5s_nbits", 32'(fnb[2]), 32'd7);
      check("5s_stop", 32'(fst[2]), 32'd24);

      // 8O2 back-to-back
      cfg(2'b11, 1'b1, 1'b1, 1'b0, 1'b0);
      push(8'hA5);
      push(8'h3C);
      wait_done(5);
      check("8o2_a5_bits", 32'(fv[3]), 32'h34A);
      check("8o2_3c_bits", 32'(fv[4]), 32'h278);
      check("8o2_nbits", 32'(fnb[4]), 32'd10);
      check("8o2_stop", 32'(fst[3]), 32'd32);

      // reset mid-DATA
      cfg(2'b11, 1'b0, 1'b0, 1'b0, 1'b0);
      push(8'h0F);
      wait_load(6);
      repeat (70) @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("async_rst_txd", 32'(txd), 32'd1);
      check("async_rst_busy", 32'(tx_busy), 32'd0);
      check("async_rst_rd_en", 32'(fifo_rd_en), 32'd0);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (30) @(negedge clk);
      check("post_rst_no_read", 32'(rd_en_cnt), 32'd6);
      push(8'h81);
      wait_done(7);

      // break mid-frame for 20 ticks
      push(8'h96);
      wait_load(8);
      repeat (40) @(negedge clk);
      set_break = 1'b1;
      repeat (30) @(negedge clk);
      check("break_txd_low", 32'(txd), 32'd0);
      repeat (30) @(negedge clk);
      set_break = 1'b0;
      wait_done(8);

      check("rd_en_per_byte", 32'(rd_en_cnt), 32'(pushes));
      check("frames_total", 32'(frames), 32'd8);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish, expected completion before 2ms");
      $fatal(1);
   end

endmodule
